// File: rtl/sb_ccff_loader.sv
// sb_ccff_loader: serialises a configuration bitstream into a switch-block ccff chain with optional parity verify
module sb_ccff_loader #(
    parameter int CHAIN_LEN = 50,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 6
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify_en,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              error
);
    typedef enum logic [1:0] {IDLE, LOAD, VERIFY} state_t;
    localparam logic [CNT_W-1:0] LEN    = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] WW     = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    state_t state, state_nxt;
    logic [WORD_W-1:0] sh_buf;
    logic [CNT_W-1:0] buf_cnt, acc_cnt, bit_cnt, vfy_cnt, rem, take;
    logic verify_q, par_ld, par_rb, accept, shift, load_last, vfy_last;

    // next state plus the combinational chain controls, so pReset silences the chain at once
    always_comb begin
        rem = LEN - acc_cnt;
        take = (rem > WW) ? WW : rem;
        busy = state != IDLE;
        cfg_ready = (state == LOAD) && (buf_cnt[CNT_W-1:1] == '0) && (acc_cnt < LEN);
        accept = cfg_valid && cfg_ready;
        shift = (state == LOAD) ? (buf_cnt != '0) : (state == VERIFY);
        ccff_shift_en = shift;
        ccff_head = (state == LOAD) ? sh_buf[0] : (state == VERIFY) && ccff_tail;
        load_last = (state == LOAD) && shift && (bit_cnt == LEN_M1);
        vfy_last = (state == VERIFY) && (vfy_cnt == LEN_M1);
        state_nxt = (abort && busy) ? IDLE :
                    (state == IDLE && start) ? LOAD :
                    load_last ? (verify_q ? VERIFY : IDLE) :
                    vfy_last ? IDLE : state;
    end

    // state register
    always_ff @(posedge prog_clk or posedge pReset)
        if (pReset) state <= IDLE;
        else state <= state_nxt;

    // word buffer, bit counters, running parities and sticky status
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            sh_buf <= '0;
            buf_cnt <= '0;
            acc_cnt <= '0;
            bit_cnt <= '0;
            vfy_cnt <= '0;
            par_ld <= 1'b0;
            par_rb <= 1'b0;
            verify_q <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                verify_q <= verify_en;
                buf_cnt <= '0;
                acc_cnt <= '0;
                bit_cnt <= '0;
                vfy_cnt <= '0;
                par_ld <= 1'b0;
                par_rb <= 1'b0;
                done <= 1'b0;
                error <= 1'b0;
            end
        end else if (abort) begin
            buf_cnt <= '0;
            done <= 1'b0;
        end else if (state == LOAD) begin
            if (shift) begin
                sh_buf <= sh_buf >> 1;
                buf_cnt <= buf_cnt - ONE;
                bit_cnt <= bit_cnt + ONE;
                par_ld <= par_ld ^ sh_buf[0];
            end
            if (accept) begin
                sh_buf <= cfg_data;
                buf_cnt <= take;
                acc_cnt <= acc_cnt + take;
            end
            if (load_last && !verify_q) done <= 1'b1;
        end else begin
            par_rb <= par_rb ^ ccff_tail;
            vfy_cnt <= vfy_cnt + ONE;
            if (vfy_last) begin
                done <= 1'b1;
                error <= (par_rb ^ ccff_tail) != par_ld;
            end
        end
    end
endmodule

// File: tb/tb_sb_ccff_loader.sv
// tb_sb_ccff_loader: scenario table, corner sequences and random loads checked against a bitstream/chain model
module tb_sb_ccff_loader;
    localparam int N = 50;
    logic prog_clk = 1'b0;
    logic pReset, start, verify_en, abort, cfg_valid, cfg_ready;
    logic ccff_head, ccff_tail, ccff_shift_en, busy, done, error;
    logic [7:0] cfg_data;
    logic [7:0] words [7];
    logic [N-1:0] chain = '0;
    logic [N-1:0] flip_mask = '0;
    logic [N-1:0] exp_chain;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit ver;
        int stall_word;
        bit flip;
        int exp_span;
        int exp_end;
        bit exp_err;
    } vec_t;
    vec_t vecs [4];

    sb_ccff_loader dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .verify_en(verify_en),
        .abort(abort), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en),
        .busy(busy), .done(done), .error(error)
    );

    always #5 prog_clk = ~prog_clk;

    // behavioural chain: bits enter at index 0 and leave from the top as the tail
    assign ccff_tail = chain[N-1];
    always @(posedge prog_clk) chain <= (ccff_shift_en ? {chain[N-2:0], ccff_head} : chain) ^ flip_mask;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge prog_clk);
        #1;
    endtask

    task automatic pulse_start(input bit ver);
        start = 1'b1;
        verify_en = ver;
        tick;
        start = 1'b0;
        verify_en = 1'b0;
    endtask

    task automatic run_load(input string name, input bit ver, input int stall_word, input bit rnd,
                            input bit flip, input int exp_span, input int exp_end, input bit exp_err);
        logic [N-1:0] exp_bits;
        int w = 0, ld = 0, vf = 0, first = -1, last = -1, end_cyc = -1, stall_left = 0;
        int head_err = 0, loop_err = 0, stall_err = 0, late_ready = 0;
        bit stall_used = 0;
        for (int i = 0; i < N; i++) exp_bits[i] = words[i / 8][i % 8];
        for (int k = 0; k < N; k++) exp_chain[k] = exp_bits[N-1-k];
        pulse_start(ver);
        check({name, " busy after start"}, busy, 1);
        check({name, " ready at t1"}, cfg_ready, 1);
        check({name, " done cleared"}, done, 0);
        check({name, " error cleared"}, error, 0);
        for (int c = 0; c < 400; c++) begin
            if (!busy) begin
                end_cyc = c;
                break;
            end
            if (stall_word >= 0 && !stall_used && w == stall_word && cfg_ready) begin
                stall_used = 1;
                stall_left = 6;
            end
            cfg_valid = (w < 7) && stall_left == 0 && (!rnd || $urandom_range(0, 3) != 0);
            cfg_data = words[w < 7 ? w : 6];
            start = rnd && $urandom_range(0, 15) == 0;
            flip_mask = '0;
            if (flip && ld == N && vf == 0) flip_mask[25] = 1'b1;
            if (stall_left >= 1 && stall_left <= 5 && ccff_shift_en) stall_err++;
            if (stall_left > 0) stall_left--;
            if (w == 7 && cfg_ready) late_ready++;
            if (ccff_shift_en) begin
                if (first < 0) first = c;
                last = c;
                if (ld < N) begin
                    if (ccff_head !== exp_bits[ld]) head_err++;
                    ld++;
                end else begin
                    if (ccff_head !== ccff_tail) loop_err++;
                    vf++;
                end
            end
            if (cfg_ready && cfg_valid) w++;
            tick;
        end
        start = 1'b0;
        cfg_valid = 1'b0;
        flip_mask = '0;
        check({name, " finished within budget"}, end_cyc >= 0, 1);
        check({name, " load shifts"}, ld, N);
        check({name, " verify shifts"}, vf, ver ? N : 0);
        check({name, " head bit errors"}, head_err, 0);
        check({name, " loopback errors"}, loop_err, 0);
        check({name, " shifts during stall"}, stall_err, 0);
        check({name, " ready after last word"}, late_ready, 0);
        check({name, " done"}, done, 1);
        check({name, " error"}, error, exp_err);
        check({name, " idle shift_en"}, ccff_shift_en, 0);
        check({name, " idle ready"}, cfg_ready, 0);
        if (!flip) check({name, " chain contents"}, chain, exp_chain);
        if (exp_span > 0) begin
            check({name, " first shift cycle"}, first, 1);
            check({name, " contiguous shift span"}, last - first + 1, exp_span);
        end
        if (exp_end > 0) check({name, " end cycle"}, end_cyc, exp_end);
    endtask

    initial begin
        int w, cnt;
        pReset = 1'b1;
        start = 1'b0;
        verify_en = 1'b0;
        abort = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        vecs[0] = '{0, -1, 0, 50, 51, 0};
        vecs[1] = '{0, 3, 0, -1, 57, 0};
        vecs[2] = '{1, -1, 0, 100, 101, 0};
        vecs[3] = '{1, -1, 1, 100, 101, 1};
        words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h96, 8'h5A, 8'h03};
        repeat (2) tick;
        check("reset cfg_ready", cfg_ready, 0);
        check("reset ccff_head", ccff_head, 0);
        check("reset shift_en", ccff_shift_en, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset error", error, 0);
        pReset = 1'b0;
        cfg_valid = 1'b1;
        tick;
        check("idle ignores valid ready", cfg_ready, 0);
        check("idle ignores valid shift", ccff_shift_en, 0);
        cfg_valid = 1'b0;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort in idle busy", busy, 0);
        for (int i = 0; i < 4; i++)
            run_load($sformatf("vec%0d", i), vecs[i].ver, vecs[i].stall_word, 0, vecs[i].flip,
                     vecs[i].exp_span, vecs[i].exp_end, vecs[i].exp_err);
        repeat (3) tick;
        check("error sticky", error, 1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("idle abort keeps done", done, 1);
        check("idle abort keeps error", error, 1);
        pulse_start(0);
        check("restart clears error", error, 0);
        w = 0;
        cnt = 0;
        for (int c = 0; c < 200 && cnt < 20; c++) begin
            cfg_valid = w < 7;
            cfg_data = words[w < 7 ? w : 6];
            if (ccff_shift_en) cnt++;
            if (cfg_ready && cfg_valid) w++;
            tick;
        end
        check("abort reached 20 shifts", cnt, 20);
        cfg_valid = 1'b0;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort shift_en", ccff_shift_en, 0);
        check("abort done", done, 0);
        check("abort ready", cfg_ready, 0);
        run_load("after_abort", 0, -1, 0, 0, 50, 51, 0);
        pulse_start(1);
        w = 0;
        cnt = 0;
        for (int c = 0; c < 200 && cnt < 30; c++) begin
            cfg_valid = w < 7;
            cfg_data = words[w < 7 ? w : 6];
            if (ccff_shift_en) cnt++;
            if (cfg_ready && cfg_valid) w++;
            tick;
        end
        check("reset test reached 30 shifts", cnt, 30);
        check("reset test busy before", busy, 1);
        #3;
        pReset = 1'b1;
        #1;
        check("async reset shift_en", ccff_shift_en, 0);
        check("async reset busy", busy, 0);
        check("async reset ready", cfg_ready, 0);
        check("async reset head", ccff_head, 0);
        check("async reset done", done, 0);
        check("async reset error", error, 0);
        cfg_valid = 1'b0;
        tick;
        pReset = 1'b0;
        tick;
        check("post reset busy", busy, 0);
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 7; j++) words[j] = 8'($urandom);
            run_load($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), -1, 1, 0, -1, -1, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
